// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// FSM state encoding and the winner-index width helper.
package interrupt_controller_pkg;

    // Register offsets relative to BASE_ADDR
    localparam logic [1:0] INTC_PENDING = 2'd0;
    localparam logic [1:0] INTC_MASK    = 2'd1;
    localparam logic [1:0] INTC_ACTIVE  = 2'd2;
    localparam logic [1:0] INTC_EDGE    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } intc_state_e;

    // Winner index width: clog2(n), never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/interrupt_controller_sync.sv
// irq_synchronizer: SYNC_STAGES-deep flop chain for one asynchronous request
// line. With INTC_EDGE_TRIGGER_EN defined it also produces a one-cycle pulse
// on each synchronised 0->1 transition.
module irq_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_irq,
    output logic o_sync
`ifdef INTC_EDGE_TRIGGER_EN
    ,
    output logic o_rise
`endif
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift the raw line through the metastability chain
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) r_chain <= '0;
        else          r_chain <= {r_chain[SYNC_STAGES-2:0], i_irq};
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

`ifdef INTC_EDGE_TRIGGER_EN
    logic r_prev;

    // Remember the previous synchronised level for rising-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_prev <= 1'b0;
        else          r_prev <= o_sync;
    end

    assign o_rise = o_sync & ~r_prev;
`endif

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: synchronises request lines, latches PENDING, arbitrates
// the lowest enabled index and sequences the CPU irq/ack/eoi handshake.
// Build option INTC_EDGE_TRIGGER_EN adds the EDGE register and per-line
// edge-triggered pending bits; without it every line is level-sensitive.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int          NUM_IRQ     = 8,
    parameter logic [15:0] BASE_ADDR   = 16'hFF00,
    parameter logic [15:0] VECTOR_BASE = 16'h0010,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [15:0]        address_bus,
    input  logic [15:0]        data_in,
    output logic [15:0]        data_out,
    output logic               data_oe,
    input  logic               r,
    input  logic               w,
    output logic               cpu_irq,
    output logic [15:0]        cpu_vector,
    input  logic               cpu_ack,
    input  logic               cpu_eoi
);

    localparam int IDX_W = idx_width(NUM_IRQ);

    logic [NUM_IRQ-1:0] w_sync;
    logic [NUM_IRQ-1:0] w_pending_nxt;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_active;
    logic [NUM_IRQ-1:0] w_req;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   r_winner;
    logic               r_cpu_irq;
    logic [15:0]        r_cpu_vector;
    intc_state_e        r_state;
    intc_state_e        w_state_nxt;
    logic               w_take;
    logic               w_accept;
    logic               w_done;
    logic [15:0]        w_offset;
    logic               w_in_range;
    logic               w_wr_mask;
    logic [15:0]        w_rdata;
    logic               w_unused;

    // Upper write-data bits beyond NUM_IRQ carry no state
    assign w_unused = ^data_in;

    // Bus decode: window of four registers starting at BASE_ADDR
    assign w_offset   = address_bus - BASE_ADDR;
    assign w_in_range = (w_offset[15:2] == 14'd0);
    assign w_wr_mask  = w & w_in_range & (w_offset[1:0] == INTC_MASK);

`ifdef INTC_EDGE_TRIGGER_EN
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] r_edge;
    logic [NUM_IRQ-1:0] w_w1c;
    logic [NUM_IRQ-1:0] w_ack_clr;
    logic               w_wr_pending;
    logic               w_wr_edge;

    assign w_wr_pending = w & w_in_range & (w_offset[1:0] == INTC_PENDING);
    assign w_wr_edge    = w & w_in_range & (w_offset[1:0] == INTC_EDGE);
    assign w_w1c        = w_wr_pending ? data_in[NUM_IRQ-1:0] : '0;
    assign w_ack_clr    = w_accept ? (NUM_IRQ'(1) << r_winner) : '0;

    // Edge lines are sticky (a new edge beats W1C/ack clear); level lines track the sync output
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_pending_nxt = r_pending;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (!r_edge[i])                    w_pending_nxt[i] = w_sync[i];
            else if (w_rise[i])                w_pending_nxt[i] = 1'b1;
            else if (w_w1c[i] || w_ack_clr[i]) w_pending_nxt[i] = 1'b0;
        end
    end

    // EDGE select register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       r_edge <= '0;
        else if (w_wr_edge) r_edge <= data_in[NUM_IRQ-1:0];
    end
`else
    assign w_pending_nxt = w_sync;
`endif

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        irq_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .i_irq   (irq_in[g]),
            .o_sync  (w_sync[g])
`ifdef INTC_EDGE_TRIGGER_EN
            ,
            .o_rise  (w_rise[g])
`endif
        );
    end

    // PENDING and MASK registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_wr_mask) r_mask <= data_in[NUM_IRQ-1:0];
        end
    end

    // Priority encoder: lowest pending & enabled index wins
    assign w_req = r_pending & r_mask;
    always_comb begin
        w_pick = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_req[i]) w_pick = IDX_W'(i);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next state; ack beats a same-cycle withdrawal of the winner
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_state_nxt = ST_REQ;
                    w_take      = 1'b1;
                end
            end
            ST_REQ: begin
                if (cpu_ack) begin
                    w_state_nxt = ST_SERVICE;
                    w_accept    = 1'b1;
                end else if (!w_req[r_winner]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (cpu_eoi) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Winner/vector latch, registered cpu_irq and in-service tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_winner     <= '0;
            r_cpu_vector <= VECTOR_BASE;
            r_cpu_irq    <= 1'b0;
            r_active     <= '0;
        end else begin
            r_cpu_irq <= (w_state_nxt == ST_REQ);
            if (w_take) begin
                r_winner     <= w_pick;
                r_cpu_vector <= VECTOR_BASE + (16'(w_pick) << 1);
            end
            if (w_accept)    r_active <= NUM_IRQ'(1) << r_winner;
            else if (w_done) r_active <= '0;
        end
    end

    assign cpu_irq    = r_cpu_irq;
    assign cpu_vector = r_cpu_vector;

    // Combinational read mux; unused upper bits read 0
    always_comb begin
        w_rdata = 16'h0000;
        case (w_offset[1:0])
            INTC_PENDING: w_rdata = 16'(r_pending);
            INTC_MASK:    w_rdata = 16'(r_mask);
            INTC_ACTIVE:  w_rdata = 16'(r_active);
`ifdef INTC_EDGE_TRIGGER_EN
            INTC_EDGE:    w_rdata = 16'(r_edge);
`endif
            default:      w_rdata = 16'h0000;
        endcase
    end

    assign data_oe  = r & w_in_range;
    assign data_out = data_oe ? w_rdata : 16'h0000;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller (default 8 lines, FF00 base,
// 0x0010 vector base). Expected values come from constants and a small
// behavioural priority model. Edge scenarios run only when
// INTC_EDGE_TRIGGER_EN is defined.
module tb_interrupt_controller;

    localparam logic [15:0] BASE = 16'hFF00;
    localparam logic [15:0] VB   = 16'h0010;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  irq_in;
    logic [15:0] address_bus;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_oe;
    logic        r;
    logic        w;
    logic        cpu_irq;
    logic [15:0] cpu_vector;
    logic        cpu_ack;
    logic        cpu_eoi;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] rd;
    logic        oe;
    bit          ok;

    interrupt_controller dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .irq_in      (irq_in),
        .address_bus (address_bus),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .r           (r),
        .w           (w),
        .cpu_irq     (cpu_irq),
        .cpu_vector  (cpu_vector),
        .cpu_ack     (cpu_ack),
        .cpu_eoi     (cpu_eoi)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        address_bus = addr;
        data_in     = data;
        w           = 1'b1;
        @(posedge clk);
        #1;
        w = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [15:0] data, output logic en);
        address_bus = addr;
        r           = 1'b1;
        #1;
        data = data_out;
        en   = data_oe;
        r    = 1'b0;
    endtask

    task automatic pulse_ack();
        cpu_ack = 1'b1;
        @(posedge clk);
        #1;
        cpu_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        cpu_eoi = 1'b1;
        @(posedge clk);
        #1;
        cpu_eoi = 1'b0;
    endtask

    task automatic wait_irq(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (cpu_irq === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; irq_in = '0; address_bus = '0; data_in = '0;
        r = 1'b0; w = 1'b0; cpu_ack = 1'b0; cpu_eoi = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", cpu_irq); end
        total++; if (cpu_vector !== VB) begin bad++; $display("FAIL reset_vector: got %h want %h", cpu_vector, VB); end
        total++; if (data_oe !== 1'b0 || data_out !== 16'h0) begin bad++; $display("FAIL reset_bus: oe=%b out=%h want 0/0000", data_oe, data_out); end
        bus_read(BASE + 16'd0, rd, oe);
        total++; if (rd !== 16'h0 || oe !== 1'b1) begin bad++; $display("FAIL reset_pending: got %h oe=%b want 0000 oe=1", rd, oe); end
        bus_read(BASE + 16'd1, rd, oe);
        total++; if (rd !== 16'h0) begin bad++; $display("FAIL reset_mask: got %h want 0000", rd); end
        bus_read(BASE + 16'd2, rd, oe);
        total++; if (rd !== 16'h0) begin bad++; $display("FAIL reset_active: got %h want 0000", rd); end
    endtask

    task automatic test_single_irq();
        bit early;
        do_reset();
        bus_write(BASE + 16'd1, 16'h0004);
        irq_in[2] = 1'b1;
        early = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            if (cpu_irq !== 1'b0) early = 1'b1;
        end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL latency_early: cpu_irq rose before 4th posedge"); end
        tick(1);
        total++; if (cpu_irq !== 1'b1) begin bad++; $display("FAIL latency_4th: got %b want 1", cpu_irq); end
        total++; if (cpu_vector !== 16'h0014) begin bad++; $display("FAIL single_vector: got %h want 0014", cpu_vector); end
        pulse_ack();
        total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL single_irq_after_ack: got %b want 0", cpu_irq); end
        bus_read(BASE + 16'd2, rd, oe);
        total++; if (rd !== 16'h0004) begin bad++; $display("FAIL single_active: got %h want 0004", rd); end
        pulse_eoi();
        bus_read(BASE + 16'd2, rd, oe);
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL single_active_eoi: got %h want 0000", rd); end
        irq_in = '0;
    endtask

    task automatic test_priority();
        do_reset();
        bus_write(BASE + 16'd1, 16'h00FF);
        irq_in = 8'b0010_0010;
        wait_irq(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL prio_timeout: cpu_irq never rose"); end
        total++; if (cpu_vector !== 16'h0012) begin bad++; $display("FAIL prio_vector1: got %h want 0012", cpu_vector); end
        pulse_ack();
        bus_read(BASE + 16'd2, rd, oe);
        total++; if (rd !== 16'h0002) begin bad++; $display("FAIL prio_active1: got %h want 0002", rd); end
        irq_in[1] = 1'b0;
        tick(4);
        pulse_eoi();
        total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL prio_idle_gap: got %b want 0", cpu_irq); end
        tick(1);
        total++; if (cpu_irq !== 1'b1 || cpu_vector !== 16'h001A) begin bad++; $display("FAIL prio_second: irq=%b vec=%h want 1/001a", cpu_irq, cpu_vector); end
        pulse_ack();
        irq_in = '0;
        tick(4);
        pulse_eoi();
    endtask

    task automatic test_freeze();
        bit stable;
        do_reset();
        bus_write(BASE + 16'd1, 16'h00FF);
        irq_in[3] = 1'b1;
        wait_irq(ok);
        total++; if (ok !== 1'b1 || cpu_vector !== 16'h0016) begin bad++; $display("FAIL freeze_start: ok=%b vec=%h want 1/0016", ok, cpu_vector); end
        irq_in[0] = 1'b1;
        stable = 1'b1;
        repeat (6) begin
            tick(1);
            if (cpu_vector !== 16'h0016 || cpu_irq !== 1'b1) stable = 1'b0;
        end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL freeze_hold: vec=%h irq=%b want 0016/1", cpu_vector, cpu_irq); end
        pulse_ack();
        bus_read(BASE + 16'd2, rd, oe);
        total++; if (rd !== 16'h0008) begin bad++; $display("FAIL freeze_active: got %h want 0008", rd); end
    endtask

    task automatic test_mask_drop();
        do_reset();
        bus_write(BASE + 16'd1, 16'h00FF);
        irq_in[4] = 1'b1;
        wait_irq(ok);
        total++; if (ok !== 1'b1 || cpu_vector !== 16'h0018) begin bad++; $display("FAIL drop_start: ok=%b vec=%h want 1/0018", ok, cpu_vector); end
        bus_write(BASE + 16'd1, 16'h0000);
        tick(1);
        total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL drop_irq: got %b want 0", cpu_irq); end
        pulse_ack();
        bus_read(BASE + 16'd2, rd, oe);
        total++; if (rd !== 16'h0000 || cpu_irq !== 1'b0) begin bad++; $display("FAIL drop_active: got %h irq=%b want 0000/0", rd, cpu_irq); end
    endtask

    task automatic test_regs();
        do_reset();
        bus_write(BASE + 16'd1, 16'hABCD);
        bus_read(BASE + 16'd1, rd, oe);
        total++; if (rd !== 16'h00CD) begin bad++; $display("FAIL regs_mask_width: got %h want 00cd", rd); end
        bus_write(BASE + 16'd2, 16'hFFFF);
        bus_read(BASE + 16'd2, rd, oe);
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL regs_active_ro: got %h want 0000", rd); end
        bus_write(BASE + 16'd3, 16'hFFFF);
        bus_read(BASE + 16'd3, rd, oe);
`ifdef INTC_EDGE_TRIGGER_EN
        total++; if (rd !== 16'h00FF || oe !== 1'b1) begin bad++; $display("FAIL regs_edge: got %h oe=%b want 00ff/1", rd, oe); end
`else
        total++; if (rd !== 16'h0000 || oe !== 1'b1) begin bad++; $display("FAIL regs_edge: got %h oe=%b want 0000/1", rd, oe); end
`endif
        bus_read(BASE + 16'd4, rd, oe);
        total++; if (rd !== 16'h0000 || oe !== 1'b0) begin bad++; $display("FAIL regs_out_of_range: got %h oe=%b want 0000/0", rd, oe); end
        bus_read(BASE - 16'd1, rd, oe);
        total++; if (oe !== 1'b0) begin bad++; $display("FAIL regs_below_base: oe=%b want 0", oe); end
        address_bus = BASE + 16'd1;
        #1;
        total++; if (data_oe !== 1'b0 || data_out !== 16'h0) begin bad++; $display("FAIL regs_no_strobe: oe=%b out=%h want 0/0000", data_oe, data_out); end
    endtask

    task automatic test_random();
        logic [7:0] pat, msk, req;
        int         win;
        for (int it = 0; it < 24; it++) begin
            do_reset();
            pat = 8'($urandom_range(0, 255));
            msk = 8'($urandom_range(0, 255));
            req = pat & msk;
            win = -1;
            for (int b = 7; b >= 0; b--) if (req[b]) win = b;
            bus_write(BASE + 16'd1, {8'h00, msk});
            irq_in = pat;
            if (win < 0) begin
                tick(6);
                total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL rand_noreq it=%0d: irq=%b want 0 (pat=%h msk=%h)", it, cpu_irq, pat, msk); end
                bus_read(BASE + 16'd0, rd, oe);
                total++; if (rd !== {8'h00, pat}) begin bad++; $display("FAIL rand_pending it=%0d: got %h want %h", it, rd, {8'h00, pat}); end
            end else begin
                wait_irq(ok);
                total++; if (ok !== 1'b1 || cpu_vector !== VB + 16'(2 * win)) begin bad++; $display("FAIL rand_vector it=%0d: ok=%b vec=%h want %h", it, ok, cpu_vector, VB + 16'(2 * win)); end
                pulse_ack();
                bus_read(BASE + 16'd2, rd, oe);
                total++; if (rd !== (16'h1 << win)) begin bad++; $display("FAIL rand_active it=%0d: got %h want %h", it, rd, 16'h1 << win); end
                irq_in = '0;
                tick(4);
                pulse_eoi();
                bus_read(BASE + 16'd2, rd, oe);
                total++; if (rd !== 16'h0 || cpu_irq !== 1'b0) begin bad++; $display("FAIL rand_eoi it=%0d: active=%h irq=%b want 0000/0", it, rd, cpu_irq); end
            end
        end
    endtask

`ifdef INTC_EDGE_TRIGGER_EN
    task automatic test_edge();
        do_reset();
        bus_write(BASE + 16'd3, 16'h0001);
        bus_write(BASE + 16'd1, 16'h0001);
        irq_in[0] = 1'b1;
        tick(2);
        irq_in[0] = 1'b0;
        wait_irq(ok);
        tick(3);
        bus_read(BASE + 16'd0, rd, oe);
        total++; if (ok !== 1'b1 || rd !== 16'h0001) begin bad++; $display("FAIL edge_sticky: ok=%b pending=%h want 1/0001", ok, rd); end
        pulse_ack();
        bus_read(BASE + 16'd0, rd, oe);
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL edge_ack_clear: got %h want 0000", rd); end
        pulse_eoi();
        tick(3);
        irq_in[0] = 1'b1;
        tick(2);
        bus_write(BASE + 16'd0, 16'h0001);
        bus_read(BASE + 16'd0, rd, oe);
        total++; if (rd !== 16'h0001) begin bad++; $display("FAIL edge_set_beats_w1c: got %h want 0001", rd); end
        bus_write(BASE + 16'd0, 16'h0001);
        bus_read(BASE + 16'd0, rd, oe);
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL edge_w1c: got %h want 0000", rd); end
        tick(2);
        total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL edge_withdraw: irq=%b want 0", cpu_irq); end
    endtask
`endif

    task automatic test_async_reset();
        do_reset();
        bus_write(BASE + 16'd1, 16'h0080);
        irq_in[7] = 1'b1;
        wait_irq(ok);
        pulse_ack();
        bus_read(BASE + 16'd2, rd, oe);
        total++; if (ok !== 1'b1 || rd !== 16'h0080) begin bad++; $display("FAIL areset_setup: ok=%b active=%h want 1/0080", ok, rd); end
        #1;
        reset_n = 1'b0;
        #1;
        total++; if (cpu_irq !== 1'b0 || cpu_vector !== VB) begin bad++; $display("FAIL areset_outputs: irq=%b vec=%h want 0/%h", cpu_irq, cpu_vector, VB); end
        bus_read(BASE + 16'd2, rd, oe);
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL areset_active: got %h want 0000", rd); end
        bus_read(BASE + 16'd1, rd, oe);
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL areset_mask: got %h want 0000", rd); end
        irq_in = '0;
        tick(1);
        reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        test_reset();
        test_single_irq();
        test_priority();
        test_freeze();
        test_mask_drop();
        test_regs();
        test_random();
`ifdef INTC_EDGE_TRIGGER_EN
        test_edge();
`endif
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
